// File: rtl/cc_bdi_width_adapter_if.sv
// Bundle of both stream sides of the bdi width adapter: the SW-bit
// PreProcessor word stream in and the CCW-bit core beat stream out.
// The 'slave' modport is the adapter's view; 'master' is the surrounding
// environment (PreProcessor on one side, core datapath on the other).
interface cc_bdi_width_adapter_if #(
    parameter int SW  = 32,
    parameter int CCW = 8
);
    localparam int SB  = SW / 8;
    localparam int CB  = CCW / 8;
    localparam int SZW = $clog2(CB) + 1;

    // PreProcessor side
    logic [SW-1:0]  bdi;
    logic           bdi_valid;
    logic           bdi_ready;
    logic [3:0]     bdi_type;
    logic           bdi_eot;
    logic           bdi_eoi;
    logic [SB-1:0]  bdi_valid_bytes;
    logic [SB-1:0]  bdi_pad_loc;
    logic           abort;

    // Core side
    logic [CCW-1:0] cc_bdi;
    logic           cc_valid;
    logic           cc_ready;
    logic [3:0]     cc_type;
    logic [CB-1:0]  cc_valid_bytes;
    logic [CB-1:0]  cc_pad_loc;
    logic [SZW-1:0] cc_size;
    logic           cc_eot;
    logic           cc_eoi;

    modport slave (
        input  bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi,
               bdi_valid_bytes, bdi_pad_loc, abort, cc_ready,
        output bdi_ready, cc_bdi, cc_valid, cc_type, cc_valid_bytes,
               cc_pad_loc, cc_size, cc_eot, cc_eoi
    );

    modport master (
        output bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi,
               bdi_valid_bytes, bdi_pad_loc, abort, cc_ready,
        input  bdi_ready, cc_bdi, cc_valid, cc_type, cc_valid_bytes,
               cc_pad_loc, cc_size, cc_eot, cc_eoi
    );
endinterface

// File: rtl/cc_bdi_width_adapter.sv
// Serialises SW-bit bdi words into CCW-bit core beats, most-significant
// beat first. Trailing beats with no valid bytes are skipped; an all-zero
// mask still produces exactly one beat so empty segments carry eot/eoi.
module cc_bdi_width_adapter #(
    parameter int SW  = 32,
    parameter int CCW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cc_bdi_width_adapter_if.slave bus
);
    localparam int R   = SW / CCW;
    localparam int CB  = CCW / 8;
    localparam int SB  = SW / 8;
    localparam int IW  = (R > 1) ? $clog2(R) : 1;
    localparam int SZW = $clog2(CB) + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_reg;
    state_t         state_next;

    logic [SW-1:0]  data_reg;
    logic [SB-1:0]  vb_reg;
    logic [SB-1:0]  pad_reg;
    logic [3:0]     type_reg;
    logic           eot_reg;
    logic           eoi_reg;
    logic [IW-1:0]  idx_reg;
    logic [IW-1:0]  lst_reg;
    logic [IW-1:0]  lst_next;

    logic [R-1:0]   beat_nz;
    logic [SZW-1:0] size_cnt;
    logic           last_beat;
    logic           beat_take;
    logic           ready_int;
    logic           load;

    // A beat of the incoming word is "non-empty" if any of its bytes is valid
    for (genvar gi = 0; gi < R; gi++) begin : g_beat_nz
        assign beat_nz[gi] = |bus.bdi_valid_bytes[SB-1-gi*CB -: CB];
    end

    assign last_beat = (idx_reg == lst_reg);
    assign beat_take = (state_reg == SHIFT) & bus.cc_ready;
    // A new word can enter when idle or when the final beat leaves this cycle;
    // abort and an asserted reset both block acceptance.
    assign ready_int = rst & ~bus.abort &
                       ((state_reg == EMPTY) | (beat_take & last_beat));
    assign load      = bus.bdi_valid & ready_int;

    // Index of the highest beat holding a valid byte (0 for an empty mask)
    always_comb begin
        lst_next = '0;
        for (int k = 0; k < R; k++) begin
            if (beat_nz[k]) begin
                lst_next = IW'(k);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_next = state_reg;
        if (bus.abort) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY:   if (bus.bdi_valid) state_next = SHIFT;
                SHIFT:   if (beat_take && last_beat && !bus.bdi_valid) state_next = EMPTY;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Holding registers: load a fresh word or shift to the next beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg <= '0;
            vb_reg   <= '0;
            pad_reg  <= '0;
            type_reg <= '0;
            eot_reg  <= 1'b0;
            eoi_reg  <= 1'b0;
            idx_reg  <= '0;
            lst_reg  <= '0;
        end else if (!bus.abort) begin
            if (load) begin
                data_reg <= bus.bdi;
                vb_reg   <= bus.bdi_valid_bytes;
                pad_reg  <= bus.bdi_pad_loc;
                type_reg <= bus.bdi_type;
                eot_reg  <= bus.bdi_eot;
                eoi_reg  <= bus.bdi_eoi;
                idx_reg  <= '0;
                lst_reg  <= lst_next;
            end else if (beat_take && !last_beat) begin
                data_reg <= data_reg << CCW;
                vb_reg   <= vb_reg << CB;
                pad_reg  <= pad_reg << CB;
                idx_reg  <= idx_reg + IW'(1);
            end
        end
    end

    // Number of valid bytes in the beat currently on the output
    always_comb begin
        size_cnt = '0;
        for (int b = 0; b < CB; b++) begin
            size_cnt = size_cnt + SZW'(vb_reg[SB-1-b]);
        end
    end

    // Output decode: beat fields only while a word is held, zeros otherwise
    always_comb begin
        bus.bdi_ready      = ready_int;
        bus.cc_valid       = 1'b0;
        bus.cc_bdi         = '0;
        bus.cc_type        = '0;
        bus.cc_valid_bytes = '0;
        bus.cc_pad_loc     = '0;
        bus.cc_size        = '0;
        bus.cc_eot         = 1'b0;
        bus.cc_eoi         = 1'b0;
        if (state_reg == SHIFT) begin
            bus.cc_valid       = 1'b1;
            bus.cc_bdi         = data_reg[SW-1 -: CCW];
            bus.cc_type        = type_reg;
            bus.cc_valid_bytes = vb_reg[SB-1 -: CB];
            bus.cc_pad_loc     = pad_reg[SB-1 -: CB];
            bus.cc_size        = size_cnt;
            bus.cc_eot         = eot_reg & last_beat;
            bus.cc_eoi         = eoi_reg & last_beat;
        end
    end
endmodule

// File: tb/tb_cc_bdi_width_adapter.sv
// Scoreboard bench for cc_bdi_width_adapter at CCW = 8, 16 and 32 (SW = 32).
// Per instance a driver issues words and queues the beats they must
// produce; an independent monitor drives cc_ready/abort and checks every
// presented beat against the head of that queue.
module tb_cc_bdi_width_adapter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  vb;
        logic [3:0]  pad;
        logic [3:0]  typ;
        logic [2:0]  size;
        logic        eot;
        logic        eoi;
    } beat_t;

    task automatic chk(input string name, input int w,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (CCW=%0d) at %0t: got 0x%h, want 0x%h",
                     name, w, $time, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int W  = 8 << gi;
        localparam int R  = 32 / W;
        localparam int CB = W / 8;
        localparam int NW = 60;

        logic  rst_n;
        logic  force_rdy = 1'b1;
        logic  done_b = 1'b0;
        beat_t q[$];

        cc_bdi_width_adapter_if #(.SW(32), .CCW(W)) bus ();

        cc_bdi_width_adapter #(.SW(32), .CCW(W)) dut (
            .clk (clk),
            .rst (rst_n),
            .bus (bus)
        );

        // Reference: split the word into R beats, keep beats up to the
        // highest one carrying a valid byte (at least one beat).
        function automatic void push_word(input logic [31:0] d, input logic [3:0] m,
                                          input logic [3:0] p, input logic [3:0] t,
                                          input logic e_t, input logic e_i);
            int          last;
            int          cbm;
            int          sh;
            beat_t       b;
            logic [3:0]  s;
            logic [63:0] dm;
            last = 0;
            cbm  = (1 << CB) - 1;
            dm   = (64'd1 << W) - 64'd1;
            for (int k = 0; k < R; k++) begin
                s = 4'((int'(m) >> (4 - CB * (k + 1))) & cbm);
                if (s != 4'd0) last = k;
            end
            for (int k = 0; k <= last; k++) begin
                sh     = 4 - CB * (k + 1);
                s      = 4'((int'(m) >> sh) & cbm);
                b.vb   = s;
                b.pad  = 4'((int'(p) >> sh) & cbm);
                b.data = 32'((64'(d) >> (32 - W * (k + 1))) & dm);
                b.size = 3'($countones(s));
                b.typ  = t;
                b.eot  = e_t && (k == last);
                b.eoi  = e_i && (k == last);
                q.push_back(b);
            end
        endfunction

        // Monitor: randomise consumer side, compare presented beats
        initial begin
            int qs;
            bit after_abort;
            after_abort  = 1'b0;
            bus.cc_ready = 1'b0;
            bus.abort    = 1'b0;
            forever begin
                @(negedge clk);
                if (force_rdy) begin
                    bus.cc_ready = 1'b1;
                    bus.abort    = 1'b0;
                end else begin
                    bus.cc_ready = ($urandom % 10) < 6;
                    bus.abort    = ($urandom % 50) == 0;
                end
                #3;
                if (rst_n) begin
                    qs = q.size();
                    chk("bdi_ready", W, 32'(bus.bdi_ready),
                        32'(!bus.abort && (qs == 0 || (qs == 1 && bus.cc_ready))));
                    chk("cc_valid", W, 32'(bus.cc_valid), 32'(qs != 0));
                    if (after_abort) chk("abort_to_empty", W, 32'(bus.cc_valid), 32'd0);
                    if (bus.cc_valid && qs != 0) begin
                        chk("cc_bdi",         W, 32'(bus.cc_bdi),         q[0].data);
                        chk("cc_valid_bytes", W, 32'(bus.cc_valid_bytes), 32'(q[0].vb));
                        chk("cc_pad_loc",     W, 32'(bus.cc_pad_loc),     32'(q[0].pad));
                        chk("cc_size",        W, 32'(bus.cc_size),        32'(q[0].size));
                        chk("cc_type",        W, 32'(bus.cc_type),        32'(q[0].typ));
                        chk("cc_eot",         W, 32'(bus.cc_eot),         32'(q[0].eot));
                        chk("cc_eoi",         W, 32'(bus.cc_eoi),         32'(q[0].eoi));
                        if (bus.cc_ready && !bus.abort) void'(q.pop_front());
                    end
                    if (bus.abort) q.delete();
                    after_abort = bus.abort;
                end else begin
                    after_abort = 1'b0;
                end
            end
        end

        // Driver: reset checks, word stream, drain, mid-word reset pulse
        initial begin
            logic [31:0] d;
            logic [3:0]  m, p, t;
            logic        e_t, e_i;
            bit          acc;
            int          gap;
            rst_n               = 1'b0;
            bus.bdi_valid       = 1'b0;
            bus.bdi             = '0;
            bus.bdi_type        = '0;
            bus.bdi_eot         = 1'b0;
            bus.bdi_eoi         = 1'b0;
            bus.bdi_valid_bytes = '0;
            bus.bdi_pad_loc     = '0;
            #1;
            chk("rst_bdi_ready", W, 32'(bus.bdi_ready), 32'd0);
            chk("rst_cc_valid",  W, 32'(bus.cc_valid),  32'd0);
            chk("rst_cc_bdi",    W, 32'(bus.cc_bdi),    32'd0);
            chk("rst_cc_size",   W, 32'(bus.cc_size),   32'd0);
            repeat (2) @(negedge clk);
            #1 rst_n = 1'b1;
            #1 chk("ready_after_rst", W, 32'(bus.bdi_ready), 32'd1);
            force_rdy = 1'b0;
            @(negedge clk);

            for (int n = 0; n < NW; n++) begin
                t = 4'($urandom % 16);
                if (n == 0) begin
                    d = 32'hA1B2C3D4; m = 4'b1111; p = 4'b0000; e_t = 1'b1; e_i = 1'b0;
                end else if (n == 1) begin
                    d = 32'hA1B2C3D4; m = 4'b1100; p = 4'b0010; e_t = 1'b1; e_i = 1'b1;
                end else if (n == 2) begin
                    d = $urandom; m = 4'b0000; p = 4'b0000; e_t = 1'b1; e_i = 1'b0;
                end else begin
                    d = $urandom;
                    case ($urandom % 4)
                        0, 1:    m = 4'b1111;
                        2: begin
                            case ($urandom % 4)
                                0:       m = 4'b1000;
                                1:       m = 4'b1100;
                                2:       m = 4'b1110;
                                default: m = 4'b0000;
                            endcase
                        end
                        default: m = 4'($urandom % 16);
                    endcase
                    p   = (($urandom % 3) == 0) ? 4'b0000 : 4'(1 << ($urandom % 4));
                    e_t = ($urandom % 4) == 0;
                    e_i = e_t && (($urandom % 2) == 1);
                end
                gap = (($urandom % 4) == 0) ? 1 + int'($urandom % 2) : 0;
                repeat (gap) begin
                    bus.bdi_valid = 1'b0;
                    @(negedge clk);
                end
                bus.bdi             = d;
                bus.bdi_valid_bytes = m;
                bus.bdi_pad_loc     = p;
                bus.bdi_type        = t;
                bus.bdi_eot         = e_t;
                bus.bdi_eoi         = e_i;
                bus.bdi_valid       = 1'b1;
                acc = 1'b0;
                for (int c = 0; c < 200 && !acc; c++) begin
                    #4;
                    if (bus.bdi_ready) begin
                        acc = 1'b1;
                        push_word(d, m, p, t, e_t, e_i);
                    end
                    @(negedge clk);
                end
                chk("word_accepted", W, 32'(acc), 32'd1);
            end
            bus.bdi_valid = 1'b0;

            for (int c = 0; c < 300 && q.size() != 0; c++) begin
                @(negedge clk);
                #4;
            end
            chk("drained", W, 32'(q.size()), 32'd0);

            // Asynchronous reset while a word is held
            force_rdy = 1'b1;
            @(negedge clk);
            bus.bdi             = 32'h5A6B7C8D;
            bus.bdi_valid_bytes = 4'b1111;
            bus.bdi_pad_loc     = 4'b0000;
            bus.bdi_type        = 4'h9;
            bus.bdi_eot         = 1'b1;
            bus.bdi_eoi         = 1'b1;
            bus.bdi_valid       = 1'b1;
            #4;
            chk("pre_rst_accept", W, 32'(bus.bdi_ready), 32'd1);
            push_word(32'h5A6B7C8D, 4'b1111, 4'b0000, 4'h9, 1'b1, 1'b1);
            @(negedge clk);
            bus.bdi_valid = 1'b0;
            #1 rst_n = 1'b0;
            #1;
            chk("arst_cc_valid",  W, 32'(bus.cc_valid),       32'd0);
            chk("arst_cc_bdi",    W, 32'(bus.cc_bdi),         32'd0);
            chk("arst_cc_type",   W, 32'(bus.cc_type),        32'd0);
            chk("arst_cc_vb",     W, 32'(bus.cc_valid_bytes), 32'd0);
            chk("arst_cc_pad",    W, 32'(bus.cc_pad_loc),     32'd0);
            chk("arst_cc_size",   W, 32'(bus.cc_size),        32'd0);
            chk("arst_cc_eot",    W, 32'(bus.cc_eot),         32'd0);
            chk("arst_cc_eoi",    W, 32'(bus.cc_eoi),         32'd0);
            chk("arst_bdi_ready", W, 32'(bus.bdi_ready),      32'd0);
            q.delete();
            @(negedge clk);
            #1 rst_n = 1'b1;
            #1;
            chk("post_arst_ready", W, 32'(bus.bdi_ready), 32'd1);
            chk("post_arst_valid", W, 32'(bus.cc_valid),  32'd0);
            repeat (3) @(negedge clk);
            done_b = 1'b1;
        end
    end

    // Wait for all three instances, then report
    initial begin
        logic all_done;
        all_done = 1'b0;
        for (int t = 0; t < 50000 && !all_done; t++) begin
            @(posedge clk);
            all_done = g_inst[0].done_b && g_inst[1].done_b && g_inst[2].done_b;
        end
        chk("all_done", 0, 32'(all_done), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
